// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, latencies
// and the pending-result payload.
package md_sequencer_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned OP_W       = 4;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned MUL_CYCLES = 5;
   localparam int unsigned DIV_CYCLES = 10;

   typedef enum logic [OP_W-1:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
      logic            div_zero;
   } md_result_t;

   // Undefined encodings are treated like NONE and never accepted.
   function automatic logic md_op_valid(input md_op_e op);
      logic v;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: v = 1'b1;
         default:                                             v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational HI/LO arithmetic: signed/unsigned 32x32 multiply and divide.
module md_alu
   import md_sequencer_pkg::*;
(
   input  md_op_e          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] hi_next,
   output logic [XLEN-1:0] lo_next,
   output logic            div_zero
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [2*XLEN-1:0] prod;
   logic              is_div;

   assign is_div   = (op == MD_DIV) || (op == MD_DIVU);
   assign div_zero = is_div && (b == '0);

   always_comb begin
      prod    = '0;
      hi_next = '0;
      lo_next = '0;
      case (op)
         MD_MULT: begin
            prod    = (2*XLEN)'($signed(a)) * (2*XLEN)'($signed(b));
            hi_next = prod[2*XLEN-1:XLEN];
            lo_next = prod[XLEN-1:0];
         end
         MD_MULTU: begin
            prod    = (2*XLEN)'(a) * (2*XLEN)'(b);
            hi_next = prod[2*XLEN-1:XLEN];
            lo_next = prod[XLEN-1:0];
         end
         MD_DIV: begin
            // INT_MIN / -1 overflows; pin it rather than rely on wraparound.
            if (b == '0) begin
               hi_next = '0;
               lo_next = '0;
            end else if ((a == INT_MIN) && (b == '1)) begin
               hi_next = '0;
               lo_next = INT_MIN;
            end else begin
               lo_next = XLEN'($signed(a) / $signed(b));
               hi_next = XLEN'($signed(a) % $signed(b));
            end
         end
         MD_DIVU: begin
            if (b != '0) begin
               lo_next = a / b;
               hi_next = a % b;
            end
         end
         default: begin
            hi_next = '0;
            lo_next = '0;
         end
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: accepts an op, models its latency with a
// down-counter and commits the precomputed result to HI/LO at the end.
module md_sequencer
   import md_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [OP_W-1:0] md_op,
   input  logic            cancel,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   md_result_t       pend_q, pend_d;

   md_op_e          op_c;
   logic            accept_c;
   logic [XLEN-1:0] alu_hi_c;
   logic [XLEN-1:0] alu_lo_c;
   logic            alu_dz_c;

   assign op_c     = md_op_e'(md_op);
   assign accept_c = start && !cancel && (state_q == ST_IDLE) && md_op_valid(op_c);

   // Result is computed from the live operands at accept and held as pending.
   md_alu u_alu (
      .op       (op_c),
      .a        (a),
      .b        (b),
      .hi_next  (alu_hi_c),
      .lo_next  (alu_lo_c),
      .div_zero (alu_dz_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               case (op_c)
                  MD_MULT, MD_MULTU: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(MUL_CYCLES);
                     pend_d  = '{hi: alu_hi_c, lo: alu_lo_c, div_zero: alu_dz_c};
                  end
                  MD_DIV, MD_DIVU: begin
                     state_d = ST_RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     pend_d  = '{hi: alu_hi_c, lo: alu_lo_c, div_zero: alu_dz_c};
                  end
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Last RUN cycle: commit (unless divide-by-zero) and leave RUN together.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               if (!pend_q.div_zero) begin
                  hi_d = pend_q.hi;
                  lo_d = pend_q.lo;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latencies, HI/LO results, cancel, stall and reset.
module tb_md_sequencer;
   import md_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic        cancel;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   always #5 clk = ~clk;

   md_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .cancel (cancel),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   // One-cycle start pulse; operands are scrambled afterwards to prove capture.
   task automatic issue(input md_op_e op, input logic [31:0] av, input logic [31:0] bv,
                        input logic cn);
      @(negedge clk);
      start  = 1'b1;
      md_op  = op;
      a      = av;
      b      = bv;
      cancel = cn;
      @(negedge clk);
      start  = 1'b0;
      cancel = 1'b0;
      md_op  = MD_NONE;
      a      = 32'hDEAD_BEEF;
      b      = 32'h0BAD_F00D;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 30) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_md(input string tag, input md_op_e op, input logic [31:0] av,
                         input logic [31:0] bv, input int cycles,
                         input logic [31:0] eh, input logic [31:0] el);
      int n;
      issue(op, av, bv, 1'b0);
      chk({tag, " hold hi"}, hi, m_hi);
      chk({tag, " hold lo"}, lo, m_lo);
      wait_idle(n);
      chk({tag, " busy cycles"}, 32'(n), 32'(cycles));
      chk({tag, " hi"}, hi, eh);
      chk({tag, " lo"}, lo, el);
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      int n;
      reset  = 1'b1;
      start  = 1'b0;
      cancel = 1'b0;
      md_op  = MD_NONE;
      a      = '0;
      b      = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;

      run_md("mult",    MD_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_md("multu",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
      run_md("divu",    MD_DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3);
      run_md("divu big",MD_DIVU,  32'hFFFF_FFFF, 32'h10,        10, 32'hF,         32'h0FFF_FFFF);
      run_md("div neg", MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div ovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,         32'h8000_0000);

      // Moves write at the next edge and never raise busy.
      issue(MD_MTHI, 32'h11, 32'h0, 1'b0);
      chk("mthi busy", 32'(busy), 32'd0);
      chk("mthi hi", hi, 32'h11);
      chk("mthi lo", lo, m_lo);
      m_hi = 32'h11;
      issue(MD_MTLO, 32'h22, 32'h0, 1'b0);
      chk("mtlo busy", 32'(busy), 32'd0);
      chk("mtlo hi", hi, m_hi);
      chk("mtlo lo", lo, 32'h22);
      m_lo = 32'h22;

      run_md("div zero", MD_DIV, 32'h1234, 32'h0, 10, 32'h11, 32'h22);

      issue(MD_MULT, 32'd5, 32'd5, 1'b1);
      chk("cancel busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("cancel busy later", 32'(busy), 32'd0);
      chk("cancel hi", hi, 32'h11);
      chk("cancel lo", lo, 32'h22);

      // Second start while busy is dropped; first result commits on time.
      issue(MD_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b0);
      chk("stall busy", 32'(busy), 32'd1);
      start = 1'b1;
      md_op = MD_DIV;
      a     = 32'd100;
      b     = 32'd7;
      @(negedge clk);
      start = 1'b0;
      md_op = MD_NONE;
      wait_idle(n);
      chk("stall busy cycles", 32'(n), 32'd4);
      chk("stall hi", hi, 32'd3);
      chk("stall lo", lo, 32'd0);
      @(negedge clk);
      chk("stall no restart", 32'(busy), 32'd0);

      // Reset in cycle 3 of a DIV: immediate clear, no later commit.
      issue(MD_DIV, 32'd100, 32'd7, 1'b0);
      repeat (2) @(negedge clk);
      chk("pre-rst busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (14) @(negedge clk);
      chk("post-rst busy", 32'(busy), 32'd0);
      chk("post-rst hi", hi, 32'd0);
      chk("post-rst lo", lo, 32'd0);
      m_hi = '0;
      m_lo = '0;

      run_md("after rst", MD_MULT, 32'd5, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
